bm_lut_rr_arbiter: RTL and testbench
====================================

# bm_lut_rr_arbiter

Round-robin arbiter that shares one registered 4-bit lookup stage (the bitwise-complement table: 0000→1111 … 1111→0000) among N_REQ requesters. It accepts at most one operand per cycle over a per-requester valid/ready handshake. It issues the operand to the lookup stage and returns the result tagged with the requester index through a one-deep, back-pressurable response register. It sits between the microbenchmark stimulus sources and the shared lookup resource.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index; must equal ceil(log2(N_REQ))
- Operand/result width is the codebase `BITS` define (4); not a parameter
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*`BITS  operand of requester i at bits [i*`BITS +: `BITS]
- req_ready  out  N_REQ  one-hot-or-zero grant; accept = req_valid[i] & req_ready[i]
- rsp_valid  out  1  response register holds a result
- rsp_data  out  `BITS  lookup result (~operand)
- rsp_id  out  ID_W  index of the requester that issued the operand
- rsp_ready  in  1  consumer accepts the response this cycle

## Operation
- Issue enable: `issue_ok = !rsp_valid | rsp_ready`.
- Arbitration is combinational. Starting at pointer `ptr` and wrapping modulo N_REQ, select the first i with req_valid[i]. req_ready[i] = issue_ok & (i == winner). All other bits are 0. req_ready is 0 when issue_ok is 0 or no request is present.
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On accept:
  - rsp_data <= lookup(req_data[winner]), the full 16-entry complement case table;
  - rsp_id <= winner;
  - rsp_valid <= 1;
  - ptr <= (winner+1) mod N_REQ.
- With no accept, when rsp_valid & rsp_ready: rsp_valid <= 0, and rsp_data/rsp_id hold their last values.
- With rsp_valid & !rsp_ready: rsp_valid, rsp_data and rsp_id hold stable, and ptr holds.
- Simultaneous drain and accept (rsp_ready=1 while a new accept occurs): the new result overwrites the register and rsp_valid stays 1. No bubble and no loss.
- ptr advances only on an accept. With no requests it holds its value.
- Fairness: a continuously asserted requester is granted within N_REQ accepts.
- Reset (async, any time, including with rsp_valid=1 or mid-stall):
  - ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0;
  - req_ready=0 while reset is high;
  - any in-flight response is discarded.

## Timing
- Latency: an operand accepted at edge k appears on rsp_data/rsp_id with rsp_valid=1 after edge k. It is consumed at the first edge ≥k+1 where rsp_ready=1.
- Throughput: one accept per cycle while rsp_ready stays 1.
- After reset deassertion, the first accept can occur at the first clock edge.
- Outputs rsp_* are registered. req_ready is combinational from req_valid, ptr, rsp_valid and rsp_ready.

## Structure
- Shared package `bm_lut_pkg`:
  - `BITS` width constant;
  - the `lut_f` function implementing the 16-entry complement table with default 0000;
  - the ID_W derivation.
- Sub-module `bm_rr_pick`: a combinational round-robin priority picker with inputs req[N_REQ] and ptr, and outputs winner index and any. It is reused by other shared-resource arbiters.
- The top level holds ptr, the response register and the issue_ok logic.

## Test plan
- Single request: req_valid=4'b0100, req_data[11:8]=4'b0011, rsp_ready=1 → req_ready=4'b0100. The next cycle shows rsp_valid=1, rsp_data=4'b1100, rsp_id=2.
- Full contention: all four valid every cycle, ptr=0, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles, and rsp_id follows one cycle later.
- Backpressure: response pending, rsp_ready=0 for 3 cycles with requests present → req_ready=0, rsp_* stable, ptr unchanged. When rsp_ready=1 the old response drains and the next accept happens in the same cycle.
- Table endpoints: data 4'b0000 → 4'b1111; 4'b1111 → 4'b0000; 4'b1010 → 4'b0101.
- Reset mid-stall: rsp_valid=1 and rsp_ready=0, then assert reset between edges → rsp_valid, rsp_data, rsp_id and req_ready go to 0 immediately. After release, ptr=0, so requester 0 wins against 3.
- Wrap fairness: ptr=3 with requesters 0 and 3 valid → 3 is granted first, then 0.

Source files
------------

// File: rtl/bm_lut_pkg.sv
// Shared definitions for the lookup-stage microbenchmark arbiters.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bm_lut_pkg;

   // Operand and result width of the shared lookup stage
   localparam int BITS = 4;

   // Requester index width for a given requester count (at least one bit)
   function automatic int id_w_f(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Bitwise-complement lookup table, one entry per operand value
   function automatic logic [BITS-1:0] lut_f(input logic [BITS-1:0] op);
      logic [BITS-1:0] res;
      case (op)
         4'b0000: res = 4'b1111;
         4'b0001: res = 4'b1110;
         4'b0010: res = 4'b1101;
         4'b0011: res = 4'b1100;
         4'b0100: res = 4'b1011;
         4'b0101: res = 4'b1010;
         4'b0110: res = 4'b1001;
         4'b0111: res = 4'b1000;
         4'b1000: res = 4'b0111;
         4'b1001: res = 4'b0110;
         4'b1010: res = 4'b0101;
         4'b1011: res = 4'b0100;
         4'b1100: res = 4'b0011;
         4'b1101: res = 4'b0010;
         4'b1110: res = 4'b0001;
         4'b1111: res = 4'b0000;
         default: res = 4'b0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bm_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; callers gate the result with their own issue enable.
module bm_rr_pick
   import bm_lut_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_w_f(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             any
);

   int idx;

   // Scan requesters starting at ptr; the first one found wins
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!any && req[idx]) begin
            winner = ID_W'(idx);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bm_lut_rr_arbiter.sv
// Round-robin arbiter sharing one registered complement-lookup stage among N_REQ requesters.
// Latency: result registered one edge after accept; one accept per cycle sustained.
// Backpressure: rsp_ready low with a pending response blocks all grants; drain and accept may coincide.
module bm_lut_rr_arbiter
   import bm_lut_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_w_f(N_REQ)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*BITS-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  rsp_valid,
   output logic [BITS-1:0]       rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   input  logic                  rsp_ready
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] winner;
   logic            any_req;
   logic            issue_ok;
   logic            accept;
   logic [BITS-1:0] operand;
   logic [ID_W-1:0] ptr_next;

   bm_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .winner (winner),
      .any    (any_req)
   );

   // The response register can take a new result when empty or draining this cycle
   assign issue_ok = !rsp_valid || rsp_ready;
   assign accept   = issue_ok && any_req && !reset;
   assign operand  = req_data[int'(winner)*BITS +: BITS];
   assign ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

   // One-hot grant to the picked requester; nothing granted during reset
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Response register and round-robin pointer; new accept overwrites a draining result
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else if (accept) begin
         ptr       <= ptr_next;
         rsp_valid <= 1'b1;
         rsp_data  <= lut_f(operand);
         rsp_id    <= winner;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bm_lut_rr_arbiter.sv
// Randomized and directed bench for bm_lut_rr_arbiter against an abstract model.
// Latency: checks grants before each edge and the response register after it.
// Backpressure: exercises stalls, drain-with-accept and reset during a stall.
module tb_bm_lut_rr_arbiter;

   localparam int N  = 4;
   localparam int B  = 4;
   localparam int IW = 2;

   logic           clock;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*B-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [B-1:0]   rsp_data;
   logic [IW-1:0]  rsp_id;
   logic           rsp_ready;

   int n_chk;
   int n_fail;

   // reference model state
   int           m_ptr;
   logic         m_vld;
   logic [B-1:0] m_data;
   int           m_id;
   int           last_w;
   logic         last_acc;

   bm_lut_rr_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_vld  = 1'b0;
      m_data = '0;
      m_id   = 0;
   endtask

   // Apply inputs (called just after a falling edge), check grant, clock, check response
   task automatic step(input logic [N-1:0] v, input logic [N*B-1:0] d, input logic r);
      logic [N-1:0] exp_rdy;
      logic [B-1:0] op;
      int           w;
      bit           found;
      req_valid = v;
      req_data  = d;
      rsp_ready = r;
      #1;
      found = 0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
         if (!found && v[(m_ptr + k) % N]) begin
            found = 1;
            w     = (m_ptr + k) % N;
         end
      end
      last_acc = found && (!m_vld || r);
      last_w   = w;
      exp_rdy  = '0;
      if (last_acc) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clock);
      if (last_acc) begin
         op     = d[w*B +: B];
         m_vld  = 1'b1;
         m_data = ~op;
         m_id   = w;
         m_ptr  = (w + 1) % N;
      end else if (r) begin
         m_vld = 1'b0;
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      @(negedge clock);
   endtask

   initial begin
      logic [B-1:0]  hold_data;
      logic [IW-1:0] hold_id;
      logic [N*B-1:0] d;
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      model_reset();
      #2;
      req_valid = 4'b1111;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_data", 32'(rsp_data), 0);
      chk("reset_rsp_id", 32'(rsp_id), 0);
      chk("reset_req_ready", 32'(req_ready), 0);
      @(negedge clock);
      reset = 1'b0;

      // full contention from ptr=0: grants 0,1,2,3,0
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 16'h8421, 1'b1);
         chk("contention_grant", 32'(last_w), 32'(i % N));
         chk("contention_rsp_id", 32'(rsp_id), 32'(i % N));
      end

      // single request from requester 2
      step(4'b0100, 16'h0300, 1'b1);
      chk("single_rsp_data", 32'(rsp_data), 32'h0000000c);
      chk("single_rsp_id", 32'(rsp_id), 2);

      // wrap fairness: ptr now 3, requesters 0 and 3 compete
      step(4'b1001, 16'h5006, 1'b1);
      chk("wrap_first", 32'(last_w), 3);
      step(4'b1001, 16'h5006, 1'b1);
      chk("wrap_second", 32'(last_w), 0);

      // table endpoints through requester 1
      step(4'b0010, 16'h0000, 1'b1);
      chk("lut_0000", 32'(rsp_data), 32'h0000000f);
      step(4'b0010, 16'h00f0, 1'b1);
      chk("lut_1111", 32'(rsp_data), 32'h00000000);
      step(4'b0010, 16'h00a0, 1'b1);
      chk("lut_1010", 32'(rsp_data), 32'h00000005);

      // backpressure: stall for three cycles with requests present
      step(4'b0001, 16'h0007, 1'b0);
      hold_data = rsp_data;
      hold_id   = rsp_id;
      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 16'h1234, 1'b0);
         chk("stall_no_grant", 32'(last_acc), 0);
         chk("stall_data_hold", 32'(rsp_data), 32'(hold_data));
         chk("stall_id_hold", 32'(rsp_id), 32'(hold_id));
      end
      step(4'b1111, 16'h1234, 1'b1);
      chk("drain_accept", 32'(last_acc), 1);
      chk("drain_valid", 32'(rsp_valid), 1);

      // reset asserted between edges while stalled
      step(4'b0100, 16'h0900, 1'b1);
      step(4'b1001, 16'h1001, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_rsp_valid", 32'(rsp_valid), 0);
      chk("arst_rsp_data", 32'(rsp_data), 0);
      chk("arst_rsp_id", 32'(rsp_id), 0);
      chk("arst_req_ready", 32'(req_ready), 0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      step(4'b1001, 16'h1001, 1'b1);
      chk("post_reset_winner", 32'(last_w), 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         d = 16'($urandom);
         step(4'($urandom), d, ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
